// File: rtl/tdc_rd_pkg.sv
// Shared types and helpers for the TDC burst readout engine.
package tdc_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } tdc_rd_state_t;

  localparam int DATA_W_DEF = 28;
  localparam int ADDR_W_DEF = 4;

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/tdc_rr_arbiter.sv
// Combinational round-robin search: first requesting channel at or above ptr, with wrap.
module tdc_rr_arbiter
  import tdc_rd_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic [N_CH-1:0]           req,
  input  logic [ch_width(N_CH)-1:0] ptr,
  output logic                      gnt_valid,
  output logic [ch_width(N_CH)-1:0] gnt_idx
);

  localparam int CH_W = ch_width(N_CH);

  logic [CH_W-1:0] cand_s;

  // Walk the channels starting at ptr and keep the first requester.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = {CH_W{1'b0}};
    cand_s    = {CH_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      cand_s = CH_W'((int'(ptr) + k) % N_CH);
      if (!gnt_valid && req[cand_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_s;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/tdc_burst_reader.sv
// Round-robin burst reader for N_CH TDC FIFOs with programmable CSN/RDN timing.
// Optional build macro TDC_RD_ALUTRIG_EN adds the alu_trigger pulse output.
module tdc_burst_reader
  import tdc_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int N_CH      = 2,
  parameter int ADDR_BASE = 8,
  parameter int CSN_SETUP = 1,
  parameter int RDN_WIDTH = 2,
  parameter int RECOVERY  = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic                      auto_mode,
  input  logic [N_CH-1:0]           ef,
  input  logic [DATA_W-1:0]         tdc_data,
  output logic [ADDR_W-1:0]         tdc_addr,
  output logic                      csn,
  output logic                      rdn,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ch_width(N_CH)-1:0] out_ch,
  output logic                      busy,
  output logic                      burst_done
`ifdef TDC_RD_ALUTRIG_EN
  ,output logic                     alu_trigger
`endif
);

  localparam int CH_W   = ch_width(N_CH);
  localparam int PH_MAX = (CSN_SETUP > RDN_WIDTH) ? ((CSN_SETUP > RECOVERY) ? CSN_SETUP : RECOVERY)
                                                  : ((RDN_WIDTH > RECOVERY) ? RDN_WIDTH : RECOVERY);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = $clog2(MAX_BURST + 1);

  tdc_rd_state_t     state_r, next_state_s;
  logic [PH_W-1:0]   phase_r;
  logic [CNT_W-1:0]  word_cnt_r;
  logic [CH_W-1:0]   rr_ptr_r, sel_ch_r, gnt_idx_s;
  logic              gnt_valid_s, rd_req_d_r, req_edge_s, out_free_s, grant_fire_s, capture_s;
  logic              csn_nxt_s, rdn_nxt_s, busy_nxt_s, done_nxt_s;
  logic              csn_r, rdn_r, busy_r, burst_done_r, out_valid_r;
  logic [ADDR_W-1:0] tdc_addr_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CH_W-1:0]   out_ch_r;

  tdc_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (~ef),
    .ptr       (rr_ptr_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  assign req_edge_s   = rd_req & ~rd_req_d_r;
  assign out_free_s   = ~out_valid_r | out_ready;
  assign grant_fire_s = (state_r == ST_ARB) & gnt_valid_s & out_free_s;
  assign capture_s    = (state_r == ST_STROBE) & (phase_r == PH_W'(RDN_WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an empty search wins over back-pressure so idle bursts still terminate.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:    if (req_edge_s || auto_mode) next_state_s = ST_ARB;
                  else next_state_s = ST_IDLE;
      ST_ARB:     if (!gnt_valid_s) next_state_s = ST_DONE;
                  else if (out_free_s) next_state_s = ST_SETUP;
                  else next_state_s = ST_ARB;
      ST_SETUP:   if (phase_r == PH_W'(CSN_SETUP - 1)) next_state_s = ST_STROBE;
                  else next_state_s = ST_SETUP;
      ST_STROBE:  if (capture_s) next_state_s = ST_RECOVER;
                  else next_state_s = ST_STROBE;
      ST_RECOVER: if (phase_r != PH_W'(RECOVERY - 1)) next_state_s = ST_RECOVER;
                  else if (word_cnt_r == CNT_W'(MAX_BURST)) next_state_s = ST_DONE;
                  else next_state_s = ST_ARB;
      ST_DONE:    next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the pins change on the transition edge.
  always_comb begin
    csn_nxt_s  = ~((next_state_s == ST_SETUP) | (next_state_s == ST_STROBE));
    rdn_nxt_s  = ~(next_state_s == ST_STROBE);
    busy_nxt_s = (next_state_s != ST_IDLE);
    done_nxt_s = (next_state_s == ST_DONE);
  end

  // Registered pins, datapath, counters and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req_d_r   <= 1'b0;
      csn_r        <= 1'b1;
      rdn_r        <= 1'b1;
      busy_r       <= 1'b0;
      burst_done_r <= 1'b0;
      phase_r      <= {PH_W{1'b0}};
      word_cnt_r   <= {CNT_W{1'b0}};
      rr_ptr_r     <= {CH_W{1'b0}};
      sel_ch_r     <= {CH_W{1'b0}};
      tdc_addr_r   <= {ADDR_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_data_r   <= {DATA_W{1'b0}};
      out_ch_r     <= {CH_W{1'b0}};
    end else begin
      rd_req_d_r   <= rd_req;
      csn_r        <= csn_nxt_s;
      rdn_r        <= rdn_nxt_s;
      busy_r       <= busy_nxt_s;
      burst_done_r <= done_nxt_s;
      phase_r      <= (next_state_s == state_r) ? phase_r + PH_W'(1) : {PH_W{1'b0}};
      if (grant_fire_s) begin
        tdc_addr_r <= ADDR_W'(ADDR_BASE) + ADDR_W'(gnt_idx_s);
        sel_ch_r   <= gnt_idx_s;
        rr_ptr_r   <= (gnt_idx_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : gnt_idx_s + CH_W'(1);
      end else begin
        tdc_addr_r <= tdc_addr_r;
      end
      if (capture_s) begin
        out_data_r  <= tdc_data;
        out_ch_r    <= sel_ch_r;
        out_valid_r <= 1'b1;
        word_cnt_r  <= word_cnt_r + CNT_W'(1);
      end else begin
        if (out_valid_r && out_ready) out_valid_r <= 1'b0;
        else out_valid_r <= out_valid_r;
        if (state_r == ST_DONE) word_cnt_r <= {CNT_W{1'b0}};
        else word_cnt_r <= word_cnt_r;
      end
    end
  end

`ifdef TDC_RD_ALUTRIG_EN
  logic alu_trigger_r;

  // Delayed burst_done, suppressed for bursts that read nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_trigger_r <= 1'b0;
    end else begin
      alu_trigger_r <= (state_r == ST_DONE) && (word_cnt_r != {CNT_W{1'b0}});
    end
  end

  assign alu_trigger = alu_trigger_r;
`endif

  assign tdc_addr   = tdc_addr_r;
  assign csn        = csn_r;
  assign rdn        = rdn_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_ch     = out_ch_r;
  assign busy       = busy_r;
  assign burst_done = burst_done_r;

endmodule
